datapath: RTL and testbench
===========================

# datapath

Register-transfer datapath for the microprogrammed processor. It holds PC, MAR, MBR, IR, BR, ACC and MR, drives the single-port data/instruction memory, and runs one ALU operation per cycle. It consumes the 32-bit control word from the control unit and returns the opcode (`IR_out`) and the registered ALU flags (`ALUflags`), which close the microsequencing loop.

## Interface

**Parameters**
- `DW`, default 16: data word width (MBR, BR, ACC, MR, memory data).
- `AW`, default 8: address width (PC, MAR, memory address).

**Ports**
- `clk` in 1: clock. All state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `Control_Signals` in 32: control word from the CU. Bit n is Cn.
- `mem_rdata` in DW: combinational read data for `mem_addr`.
- `mem_addr` out AW: equals MAR.
- `mem_wdata` out DW: equals MBR.
- `mem_we` out 1: equals C11. Memory writes at the rising edge while high.
- `IR_out` out 8: the IR register.
- `ALUflags` out 4: registered flags {ZF, CF, OF, SF}.
- `acc_out` out DW: ACC, for debug.
- `pc_out` out AW: PC, for debug.

## Operation

**Register transfers**
- All transfers read pre-edge register values, so C3|C7 in the same cycle gives BR the old MBR.
- MBR:
  - C3: `mem_rdata`.
  - Otherwise C12: ACC.
  - C3 has priority over C12.
- IR: C4 loads MBR[15:8].
- MAR:
  - C5: MBR[7:0].
  - Otherwise C10: PC.
  - C5 has priority over C10.
- PC:
  - C14: MBR[7:0].
  - Otherwise C6: PC+1, wrapping 8'hFF to 8'h00.
  - C14 has priority over C6.
- BR: C7 loads MBR.

**ACC and ALU**
- ACC operand: the ALU sees 0 as its ACC operand when C8 is set, otherwise ACC.
- C8 alone: ACC ← 0 and flags ← {1,0,0,0}.
- If more than one ALU select (C9, C13, C15–C21) is set, the lowest-numbered one wins.
- C9 ADD:
  - CF = carry out.
  - OF = two's-complement signed overflow.
- C13 SUB (ACC−BR):
  - CF = borrow, i.e. ACC < BR unsigned.
  - OF = signed overflow.
- C15 MPY: unsigned product.
  - ACC ← product[15:0], MR ← product[31:16].
  - CF = OF = (product[31:16] != 0).
- C16 DIV: unsigned.
  - ACC ← quotient, MR ← remainder, CF = OF = 0.
  - BR == 0: ACC ← 16'hFFFF, MR ← old ACC, OF = 1, CF = 0.
- C17 SHL and C18 SHR (logical):
  - Shift amount is BR[4:0].
  - Amount 0: ACC unchanged, CF = 0.
  - Amount 1–16: CF = last bit shifted out.
  - Amount ≥ 16: result 0.
  - OF = 0.
- C19 AND, C20 OR, C21 NOT (ACC ← ~BR): CF = OF = 0.
- For every ALU op: ZF = (result == 0), SF = result[15].
- Flags hold their value when neither C8 nor an ALU select is set.
- Unused bits C0–C2 and C22–C31 are ignored.

## Timing

- Single-cycle: every transfer commits at the edge that ends the cycle in which its control bit is high.
- Memory read is combinational and captured in the same cycle.
- Memory write is a one-cycle strobe.
- `ALUflags` reflects the new ACC one cycle after the ALU op; the CU samples flags at or after the following microstep.
- Reset values:
  - PC, MAR, MBR, IR, BR, ACC, MR: 0.
  - `ALUflags` = 4'b0000.
  - `mem_we` follows `Control_Signals`, which is 0 in reset.
- Reset asserted mid-instruction clears all registers immediately, without waiting for a clock edge.
- Fetch restarts from address 0 after release.

## Structure

- Shared package `bitcruncher_pkg` holds:
  - Control-bit index constants (C_CAR_INC … C_NOT).
  - Flag index constants (FLAG_ZF=3, FLAG_CF=2, FLAG_OF=1, FLAG_SF=0).
  - `DW`/`AW` defaults.
- The package is also used by the CU.
- One sub-module, `bc_alu`: purely combinational. It takes the operand pair and an op select and returns {result, mr_result, flags}.
- The register file, priorities and flag register stay in `datapath`.

## Test plan

- **Fetch.** Memory[0] = 16'h0210 with C3, then C4, then C5|C6. Expect IR = 8'h02, MAR = 8'h10, PC = 1.
- **LOAD/ADD carry.**
  - Load ACC = 16'hFFFF, then ADD BR = 16'h0001.
  - Expect ACC = 0 and ALUflags = {1,1,0,0}.
- **SUB signed overflow.**
  - ACC = 16'h8000, BR = 1, pulse C13.
  - Expect ACC = 16'h7FFF and flags = {0,0,1,0}.
- **MPY/DIV.**
  - MPY: ACC = 16'h0100, BR = 16'h0100. Expect ACC = 0, MR = 1, CF = OF = 1.
  - DIV by 0: ACC = 7, BR = 0. Expect ACC = 16'hFFFF, MR = 7, OF = 1.
- **Priority and wrap.**
  - PC = 8'hFF with C6 → PC = 0.
  - C6|C14 with MBR = 16'h0042 → PC = 8'h42.
  - C3|C12 → MBR = `mem_rdata`.
- **STORE and reset.**
  - C12 then C11. Expect `mem_we` high for exactly one cycle with `mem_wdata` = ACC.
  - Assert `rst_n` low between clock edges. Expect all outputs 0 immediately.

Source files
------------

// File: rtl/bitcruncher_pkg.sv
// bitcruncher_pkg: definitions shared by the datapath and the control unit.
//   - Default data/address widths.
//   - Control-word bit positions (bit n of the control word is Cn).
//   - Flag bit positions inside the 4-bit {ZF, CF, OF, SF} flag vector.
//   - ALU operation encoding and the ALU select table.
//     The table is ordered from lowest to highest control bit, which is also
//     the arbitration order.
package bitcruncher_pkg;

    localparam int DEFAULT_DW = 16;
    localparam int DEFAULT_AW = 8;

    // Control word bit indices
    localparam int C_CAR_INC    = 0;
    localparam int C_CAR_LOAD   = 1;
    localparam int C_CAR_RESET  = 2;
    localparam int C_MBR_LD_MEM = 3;
    localparam int C_IR_LD      = 4;
    localparam int C_MAR_LD_MBR = 5;
    localparam int C_PC_INC     = 6;
    localparam int C_BR_LD      = 7;
    localparam int C_ACC_CLR    = 8;
    localparam int C_ADD        = 9;
    localparam int C_MAR_LD_PC  = 10;
    localparam int C_MEM_WE     = 11;
    localparam int C_MBR_LD_ACC = 12;
    localparam int C_SUB        = 13;
    localparam int C_PC_LD      = 14;
    localparam int C_MPY        = 15;
    localparam int C_DIV        = 16;
    localparam int C_SHL        = 17;
    localparam int C_SHR        = 18;
    localparam int C_AND        = 19;
    localparam int C_OR         = 20;
    localparam int C_NOT        = 21;

    // Flag vector layout: {ZF, CF, OF, SF}
    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_CLR,
        ALU_ADD,
        ALU_SUB,
        ALU_MPY,
        ALU_DIV,
        ALU_SHL,
        ALU_SHR,
        ALU_AND,
        ALU_OR,
        ALU_NOT
    } alu_op_e;

    // ALU selects in ascending control-bit order: entry 0 has highest priority.
    localparam int NUM_ALU_SEL = 9;
    localparam int ALU_SEL_BIT [NUM_ALU_SEL] = '{
        C_ADD, C_SUB, C_MPY, C_DIV, C_SHL, C_SHR, C_AND, C_OR, C_NOT
    };
    localparam alu_op_e ALU_SEL_OP [NUM_ALU_SEL] = '{
        ALU_ADD, ALU_SUB, ALU_MPY, ALU_DIV, ALU_SHL, ALU_SHR, ALU_AND, ALU_OR, ALU_NOT
    };

endpackage

// File: rtl/bc_alu.sv
// bc_alu: purely combinational ALU for the bitcruncher datapath.
// Ports:
//   a         in  DW : accumulator operand (already forced to 0 by the caller if needed)
//   b         in  DW : BR operand
//   op        in     : operation select (alu_op_e)
//   result    out DW : new ACC value
//   mr_result out DW : new MR value (meaningful for MPY and DIV only)
//   flags     out 4  : {ZF, CF, OF, SF} for result
module bc_alu
    import bitcruncher_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  alu_op_e         op,
    output logic [DW-1:0]   result,
    output logic [DW-1:0]   mr_result,
    output logic [3:0]      flags
);

    logic [DW:0]     sum_ext;
    logic [DW:0]     diff_ext;
    logic [2*DW-1:0] prod;
    logic [DW:0]     shl_ext;
    logic [DW:0]     shr_ext;
    logic [4:0]      amt;
    logic            cf;
    logic            of;

    // One extra bit on each side of the shifter catches the last bit
    // shifted out. Amounts beyond the word width shift in zeros on both
    // the result and the carry.
    assign amt      = b[4:0];
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign prod     = (2*DW)'(a) * (2*DW)'(b);
    assign shl_ext  = {1'b0, a} << amt;
    assign shr_ext  = {a, 1'b0} >> amt;

    always_comb begin
        result    = '0;
        mr_result = '0;
        cf        = 1'b0;
        of        = 1'b0;
        case (op)
            ALU_CLR: result = '0;
            ALU_ADD: begin
                result = sum_ext[DW-1:0];
                cf     = sum_ext[DW];
                of     = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            ALU_SUB: begin
                result = diff_ext[DW-1:0];
                cf     = diff_ext[DW];   // borrow: a < b unsigned
                of     = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            ALU_MPY: begin
                result    = prod[DW-1:0];
                mr_result = prod[2*DW-1:DW];
                cf        = |prod[2*DW-1:DW];
                of        = |prod[2*DW-1:DW];
            end
            ALU_DIV: begin
                if (b == '0) begin
                    // Divide by zero: saturate the quotient, keep the dividend in MR.
                    result    = '1;
                    mr_result = a;
                    of        = 1'b1;
                end else begin
                    result    = a / b;
                    mr_result = a % b;
                end
            end
            ALU_SHL: begin
                result = shl_ext[DW-1:0];
                cf     = shl_ext[DW];
            end
            ALU_SHR: begin
                result = shr_ext[DW:1];
                cf     = shr_ext[0];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOT: result = ~b;
            default: result = '0;
        endcase

        flags          = '0;
        flags[FLAG_ZF] = (result == '0);
        flags[FLAG_CF] = cf;
        flags[FLAG_OF] = of;
        flags[FLAG_SF] = result[DW-1];
    end

endmodule

// File: rtl/datapath.sv
// datapath: register-transfer datapath of the microprogrammed processor.
// Holds PC, MAR, MBR, IR, BR, ACC, MR and the registered ALU flags, and
// drives the single-port memory. One ALU operation per cycle.
// Ports:
//   clk             in  1  : clock, rising edge
//   rst_n           in  1  : asynchronous active-low reset
//   Control_Signals in  32 : control word, bit n = Cn
//   mem_rdata       in  DW : combinational memory read data for mem_addr
//   mem_addr        out AW : MAR
//   mem_wdata       out DW : MBR
//   mem_we          out 1  : C11 (memory write strobe)
//   IR_out          out 8  : IR register (opcode to the CU)
//   ALUflags        out 4  : registered {ZF, CF, OF, SF}
//   acc_out         out DW : ACC (debug)
//   pc_out          out AW : PC (debug)
module datapath
    import bitcruncher_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     Control_Signals,
    input  logic [DW-1:0]   mem_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_we,
    output logic [7:0]      IR_out,
    output logic [3:0]      ALUflags,
    output logic [DW-1:0]   acc_out,
    output logic [AW-1:0]   pc_out
);

    logic [AW-1:0] pc_reg,    pc_next;
    logic [AW-1:0] mar_reg,   mar_next;
    logic [DW-1:0] mbr_reg,   mbr_next;
    logic [7:0]    ir_reg,    ir_next;
    logic [DW-1:0] br_reg,    br_next;
    logic [DW-1:0] acc_reg,   acc_next;
    logic [DW-1:0] mr_reg,    mr_next;
    logic [3:0]    flags_reg, flags_next;

    logic [NUM_ALU_SEL-1:0] alu_sel;
    alu_op_e                alu_op;
    logic [DW-1:0]          alu_a;
    logic [DW-1:0]          alu_result;
    logic [DW-1:0]          alu_mr;
    logic [3:0]             alu_flags;

    // Bits with no consumer inside this block: CAR controls belong to the CU,
    // C22-C31 are spare, and MR has no output port.
    logic unused_bits;
    assign unused_bits = ^{Control_Signals[31:C_NOT+1],
                           Control_Signals[C_CAR_RESET:C_CAR_INC], mr_reg};

    generate
        for (genvar gi = 0; gi < NUM_ALU_SEL; gi++) begin : g_alu_sel
            assign alu_sel[gi] = Control_Signals[ALU_SEL_BIT[gi]];
        end
    endgenerate

    // Lowest-numbered ALU select wins: scan downward so the last hit is the lowest.
    // C8 on its own clears ACC through the ALU so the flags follow the zero result.
    always_comb begin
        alu_op = ALU_NONE;
        for (int i = NUM_ALU_SEL - 1; i >= 0; i--) begin
            if (alu_sel[i]) begin
                alu_op = ALU_SEL_OP[i];
            end
        end
        if ((alu_op == ALU_NONE) && Control_Signals[C_ACC_CLR]) begin
            alu_op = ALU_CLR;
        end
    end

    assign alu_a = Control_Signals[C_ACC_CLR] ? '0 : acc_reg;

    bc_alu #(
        .DW        (DW)
    ) u_alu (
        .a         (alu_a),
        .b         (br_reg),
        .op        (alu_op),
        .result    (alu_result),
        .mr_result (alu_mr),
        .flags     (alu_flags)
    );

    // Every transfer reads pre-edge register values.
    always_comb begin
        mbr_next = mbr_reg;
        if (Control_Signals[C_MBR_LD_MEM]) begin
            mbr_next = mem_rdata;
        end else if (Control_Signals[C_MBR_LD_ACC]) begin
            mbr_next = acc_reg;
        end

        ir_next = Control_Signals[C_IR_LD] ? mbr_reg[DW-1 -: 8] : ir_reg;

        mar_next = mar_reg;
        if (Control_Signals[C_MAR_LD_MBR]) begin
            mar_next = mbr_reg[AW-1:0];
        end else if (Control_Signals[C_MAR_LD_PC]) begin
            mar_next = pc_reg;
        end

        pc_next = pc_reg;
        if (Control_Signals[C_PC_LD]) begin
            pc_next = mbr_reg[AW-1:0];
        end else if (Control_Signals[C_PC_INC]) begin
            pc_next = pc_reg + AW'(1);
        end

        br_next = Control_Signals[C_BR_LD] ? mbr_reg : br_reg;

        acc_next   = acc_reg;
        flags_next = flags_reg;
        mr_next    = mr_reg;
        if (alu_op != ALU_NONE) begin
            acc_next   = alu_result;
            flags_next = alu_flags;
            if ((alu_op == ALU_MPY) || (alu_op == ALU_DIV)) begin
                mr_next = alu_mr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= '0;
            mar_reg   <= '0;
            mbr_reg   <= '0;
            ir_reg    <= '0;
            br_reg    <= '0;
            acc_reg   <= '0;
            mr_reg    <= '0;
            flags_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            mar_reg   <= mar_next;
            mbr_reg   <= mbr_next;
            ir_reg    <= ir_next;
            br_reg    <= br_next;
            acc_reg   <= acc_next;
            mr_reg    <= mr_next;
            flags_reg <= flags_next;
        end
    end

    assign mem_addr  = mar_reg;
    assign mem_wdata = mbr_reg;
    assign mem_we    = Control_Signals[C_MEM_WE];
    assign IR_out    = ir_reg;
    assign ALUflags  = flags_reg;
    assign acc_out   = acc_reg;
    assign pc_out    = pc_reg;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed scoreboard bench for datapath.
// Stimulus drives control words one cycle at a time and queues the values
// it expects; a monitor on the falling edge pops and compares them.
module tb_datapath;
    import bitcruncher_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   Control_Signals = '0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [7:0]    IR_out;
    logic [3:0]    ALUflags;
    logic [DW-1:0] acc_out;
    logic [AW-1:0] pc_out;

    always #5 clk = ~clk;

    datapath #(.DW(DW), .AW(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Control_Signals (Control_Signals),
        .mem_rdata       (mem_rdata),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .IR_out          (IR_out),
        .ALUflags        (ALUflags),
        .acc_out         (acc_out),
        .pc_out          (pc_out)
    );

    // Memory model: DUT writes land in mem; the bench presents read data
    // for one cycle through the preload override.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] preload_data = '0;
    logic          preload_valid = 1'b0;

    assign mem_rdata = preload_valid ? preload_data : mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    typedef enum logic [3:0] {F_PC, F_ADDR, F_WDATA, F_WE, F_IR, F_FLAGS, F_ACC, F_MR, F_MEM} field_e;
    typedef struct {
        string       name;
        field_e      field;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(input field_e f);
        case (f)
            F_PC:    return 32'(pc_out);
            F_ADDR:  return 32'(mem_addr);
            F_WDATA: return 32'(mem_wdata);
            F_WE:    return 32'(mem_we);
            F_IR:    return 32'(IR_out);
            F_FLAGS: return 32'(ALUflags);
            F_ACC:   return 32'(acc_out);
            F_MR:    return 32'(dut.mr_reg);
            F_MEM:   return 32'(mem[mem_addr]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string name, input field_e f, input logic [31:0] v);
        exp_t e;
        e.name  = name;
        e.field = f;
        e.exp   = v;
        sb_q.push_back(e);
    endtask

    // Monitor: compares everything queued since the last falling edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = observe(e.field);
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h (t=%0t)", e.name, act, e.exp, $time);
                end else begin
                    $display("ok   %s = %h (t=%0t)", e.name, act, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb_q.size());
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] cb(input int n);
        return 32'd1 << n;
    endfunction

    // Apply one control word for one cycle; returns 1 time unit after the edge.
    task automatic apply(input logic [31:0] cw);
        Control_Signals = cw;
        @(posedge clk);
        #1;
        Control_Signals = '0;
    endtask

    task automatic set_mbr(input logic [DW-1:0] v);
        preload_data  = v;
        preload_valid = 1'b1;
        apply(cb(C_MBR_LD_MEM));
        preload_valid = 1'b0;
    endtask

    task automatic load_br(input logic [DW-1:0] v);
        set_mbr(v);
        apply(cb(C_BR_LD));
    endtask

    // ACC <- 0 + BR; clobbers BR and MBR.
    task automatic load_acc(input logic [DW-1:0] v);
        set_mbr(v);
        apply(cb(C_BR_LD));
        apply(cb(C_ACC_CLR) | cb(C_ADD));
    endtask

    initial begin
        // Reset state
        #12;
        expect_val("reset_pc", F_PC, 0);
        expect_val("reset_addr", F_ADDR, 0);
        expect_val("reset_wdata", F_WDATA, 0);
        expect_val("reset_ir", F_IR, 0);
        expect_val("reset_flags", F_FLAGS, 0);
        expect_val("reset_acc", F_ACC, 0);
        expect_val("reset_we", F_WE, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fetch
        set_mbr(16'h0210);
        expect_val("fetch_mbr", F_WDATA, 16'h0210);
        apply(cb(C_IR_LD));
        expect_val("fetch_ir", F_IR, 8'h02);
        apply(cb(C_MAR_LD_MBR) | cb(C_PC_INC));
        expect_val("fetch_mar", F_ADDR, 8'h10);
        expect_val("fetch_pc", F_PC, 8'h01);

        // LOAD / ADD carry
        load_acc(16'hFFFF);
        expect_val("load_acc", F_ACC, 16'hFFFF);
        expect_val("load_flags", F_FLAGS, 4'b0001);
        load_br(16'h0001);
        apply(cb(C_ADD));
        expect_val("add_acc", F_ACC, 16'h0000);
        expect_val("add_flags", F_FLAGS, 4'b1100);

        // SUB signed overflow
        load_acc(16'h8000);
        load_br(16'h0001);
        apply(cb(C_SUB));
        expect_val("sub_acc", F_ACC, 16'h7FFF);
        expect_val("sub_flags", F_FLAGS, 4'b0010);

        // MPY with high half
        load_acc(16'h0100);
        load_br(16'h0100);
        apply(cb(C_MPY));
        expect_val("mpy_acc", F_ACC, 16'h0000);
        expect_val("mpy_mr", F_MR, 16'h0001);
        expect_val("mpy_flags", F_FLAGS, 4'b1110);

        // DIV by zero
        load_acc(16'h0007);
        load_br(16'h0000);
        apply(cb(C_DIV));
        expect_val("div0_acc", F_ACC, 16'hFFFF);
        expect_val("div0_mr", F_MR, 16'h0007);
        expect_val("div0_flags", F_FLAGS, 4'b0011);

        // DIV normal: 100 / 7 = 14 r 2
        load_acc(16'd100);
        load_br(16'd7);
        apply(cb(C_DIV));
        expect_val("div_acc", F_ACC, 16'd14);
        expect_val("div_mr", F_MR, 16'd2);
        expect_val("div_flags", F_FLAGS, 4'b0000);

        // Shifts: SHL by 1, SHR by 16, SHL by 0
        load_acc(16'h8001);
        load_br(16'd1);
        apply(cb(C_SHL));
        expect_val("shl1_acc", F_ACC, 16'h0002);
        expect_val("shl1_flags", F_FLAGS, 4'b0100);
        load_acc(16'h8001);
        load_br(16'd16);
        apply(cb(C_SHR));
        expect_val("shr16_acc", F_ACC, 16'h0000);
        expect_val("shr16_flags", F_FLAGS, 4'b1100);
        load_acc(16'h1234);
        load_br(16'd0);
        apply(cb(C_SHL));
        expect_val("shl0_acc", F_ACC, 16'h1234);
        expect_val("shl0_flags", F_FLAGS, 4'b0000);

        // ALU select priority: ADD beats SUB and AND
        load_acc(16'd5);
        load_br(16'd3);
        apply(cb(C_ADD) | cb(C_SUB) | cb(C_AND));
        expect_val("prio_acc", F_ACC, 16'd8);
        expect_val("prio_flags", F_FLAGS, 4'b0000);

        // NOT, OR, AND
        load_br(16'h00FF);
        apply(cb(C_NOT));
        expect_val("not_acc", F_ACC, 16'hFF00);
        expect_val("not_flags", F_FLAGS, 4'b0001);
        load_br(16'h0F0F);
        apply(cb(C_OR));
        expect_val("or_acc", F_ACC, 16'hFF0F);
        load_br(16'h00F0);
        apply(cb(C_AND));
        expect_val("and_acc", F_ACC, 16'h0000);
        expect_val("and_flags", F_FLAGS, 4'b1000);

        // Flags hold without an ALU op; C8 alone clears
        load_acc(16'h8000);
        apply(cb(C_PC_INC));
        expect_val("hold_flags", F_FLAGS, 4'b0001);
        expect_val("hold_acc", F_ACC, 16'h8000);
        apply(cb(C_ACC_CLR));
        expect_val("clr_acc", F_ACC, 16'h0000);
        expect_val("clr_flags", F_FLAGS, 4'b1000);

        // PC load, wrap, and load-over-increment priority
        set_mbr(16'h00FF);
        apply(cb(C_PC_LD));
        expect_val("pc_ld", F_PC, 8'hFF);
        apply(cb(C_PC_INC));
        expect_val("pc_wrap", F_PC, 8'h00);
        set_mbr(16'h0042);
        apply(cb(C_PC_INC) | cb(C_PC_LD));
        expect_val("pc_prio", F_PC, 8'h42);

        // MBR: memory beats ACC; MAR: MBR beats PC
        preload_data  = 16'hBEEF;
        preload_valid = 1'b1;
        apply(cb(C_MBR_LD_MEM) | cb(C_MBR_LD_ACC));
        preload_valid = 1'b0;
        expect_val("mbr_prio", F_WDATA, 16'hBEEF);
        apply(cb(C_MAR_LD_MBR) | cb(C_MAR_LD_PC));
        expect_val("mar_prio", F_ADDR, 8'hEF);

        // C3|C7 together: BR receives the old MBR
        preload_data  = 16'h1234;
        preload_valid = 1'b1;
        apply(cb(C_MBR_LD_MEM) | cb(C_BR_LD));
        preload_valid = 1'b0;
        expect_val("mbr_new", F_WDATA, 16'h1234);
        apply(cb(C_ACC_CLR) | cb(C_ADD));
        expect_val("br_old_mbr", F_ACC, 16'hBEEF);

        // STORE: MBR <- ACC, then a one-cycle write strobe
        load_acc(16'h5A5A);
        set_mbr(16'h0033);
        apply(cb(C_MAR_LD_MBR));
        expect_val("st_addr", F_ADDR, 8'h33);
        apply(cb(C_MBR_LD_ACC));
        expect_val("st_mbr_acc", F_WDATA, 16'h5A5A);
        Control_Signals = cb(C_MEM_WE);
        expect_val("st_we_hi", F_WE, 1);
        expect_val("st_wdata", F_WDATA, 16'h5A5A);
        @(posedge clk);
        #1;
        Control_Signals = '0;
        expect_val("st_we_lo", F_WE, 0);
        expect_val("st_mem", F_MEM, 16'h5A5A);

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("areset_pc", F_PC, 0);
        expect_val("areset_addr", F_ADDR, 0);
        expect_val("areset_wdata", F_WDATA, 0);
        expect_val("areset_ir", F_IR, 0);
        expect_val("areset_acc", F_ACC, 0);
        expect_val("areset_mr", F_MR, 0);
        expect_val("areset_flags", F_FLAGS, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fetch restarts from address 0
        apply(cb(C_MAR_LD_PC));
        expect_val("restart_addr", F_ADDR, 0);
        apply(cb(C_PC_INC));
        expect_val("restart_pc", F_PC, 1);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d checks left unevaluated, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
